// File: rtl/uart_pkg.sv
// Shared types and helpers for the serial receive pipeline.
package uart_pkg;

   localparam int WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } uart_rx_state_t;

   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/rx_pipe_if.sv
// Serial line in, FIFO head and status out; master drives the line and pops.
interface rx_pipe_if
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
);

   logic                   rx;
   logic                   pop_front;
   logic [WIDTH-1:0]       data_out;
   logic                   empty;
   logic                   full;
   logic [$clog2(DEPTH):0] level;
   logic                   frame_error;
   logic                   error;

   modport master (
      output rx, pop_front,
      input  data_out, empty, full, level, frame_error, error
   );

   modport slave (
      input  rx, pop_front,
      output data_out, empty, full, level, frame_error, error
   );

endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver: two-flop synchronizer, mid-bit sampling FSM, registered byte strobe.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 12_000_000,
   parameter int BAUD     = 9_600
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             rx_frame_error
);

   localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
   localparam int HALF  = CPB / 2;
   localparam int CNT_W = $clog2(CPB);

   logic             rx_meta_q, rx_sync_q;
   logic             prime_q, armed_q;
   uart_rx_state_t   state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bit_idx_q;
   logic [WIDTH-1:0] shift_q, data_q;
   logic             valid_q, frame_err_q;

   // NOTE: all state here uses non-blocking assignment so every flop sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q   <= 1'b1;
         rx_sync_q   <= 1'b1;
         prime_q     <= 1'b0;
         armed_q     <= 1'b0;
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_meta_q   <= rx;
         rx_sync_q   <= rx_meta_q;
         prime_q     <= 1'b1;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         // Start detection stays off until the line has really been seen high after reset.
         armed_q     <= armed_q | (prime_q & rx_meta_q & rx_sync_q);
         case (state_q)
            IDLE: begin
               cnt_q     <= '0;
               bit_idx_q <= '0;
               if (armed_q && !rx_sync_q) state_q <= START;
            end
            START: begin
               if (cnt_q == CNT_W'(HALF - 1)) begin
                  cnt_q   <= '0;
                  state_q <= rx_sync_q ? IDLE : DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DATA: begin
               if (cnt_q == CNT_W'(CPB - 1)) begin
                  cnt_q     <= '0;
                  shift_q   <= {rx_sync_q, shift_q[WIDTH-1:1]};
                  bit_idx_q <= bit_idx_q + 1'b1;
                  if (bit_idx_q == 3'd7) state_q <= STOP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            STOP: begin
               if (cnt_q == CNT_W'(CPB - 1)) begin
                  cnt_q <= '0;
                  if (rx_sync_q) begin
                     data_q  <= shift_q;
                     valid_q <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= WAIT_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            WAIT_IDLE: begin
               if (rx_sync_q) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rx_data        = data_q;
   assign rx_valid       = valid_q;
   assign rx_frame_error = frame_err_q;

endmodule

// File: rtl/rx_pipe.sv
// UART receiver feeding a first-word-fall-through byte FIFO with sticky error.
module rx_pipe
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 12_000_000,
   parameter int BAUD     = 9_600,
   parameter int DEPTH    = 16
) (
   input  logic       clk,
   input  logic       rst,
   rx_pipe_if.slave   bus
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;

   logic [WIDTH-1:0] rx_data;
   logic             rx_valid, rx_frame_error;

   uart_rx #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) u_rx (
      .clk            (clk),
      .rst            (rst),
      .rx             (bus.rx),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_frame_error (rx_frame_error)
   );

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic             error_q, error_d;
   logic             empty, full, push_ok, pop_ok;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
   always_comb begin
      pop_ok   = bus.pop_front && !empty;
      push_ok  = rx_valid && (!full || pop_ok);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
      error_d  = error_q | (rx_valid & full & ~pop_ok) | (bus.pop_front & empty);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         error_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         error_q  <= error_d;
      end
   end

   // NOTE: storage is not reset; empty masks data_out so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= rx_data;
   end

   assign bus.data_out    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign bus.empty       = empty;
   assign bus.full        = full;
   assign bus.level       = wr_ptr_q - rd_ptr_q;
   assign bus.frame_error = rx_frame_error;
   assign bus.error       = error_q;

endmodule

// File: tb/tb_rx_pipe.sv
// Directed bench for rx_pipe at 12 clocks per bit with a 4-entry FIFO.
module tb_rx_pipe;
   import uart_pkg::*;

   localparam int CLK_FREQ = 12_000_000;
   localparam int BAUD     = 1_000_000;
   localparam int DEPTH    = 4;
   localparam int CPB      = 12;
   localparam int FRAME    = 10 * CPB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rx_pipe_if #(.DEPTH(DEPTH)) bus ();

   rx_pipe #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD),
      .DEPTH    (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int errors   = 0;
   int fe_count = 0;

   always @(negedge clk) if (!rst && bus.frame_error) fe_count++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         hold_low;
      logic [7:0] exp_data;
      int         exp_level;
      int         exp_fe;
   } vec_t;

   vec_t vecs [5];

   // Drives one frame from a negedge; pop_at picks the clock index to pulse pop_front.
   task automatic send_frame(input logic [7:0] d, input logic stop, input int pop_at,
                             output logic emp117, output logic emp118);
      emp117 = 1'bx;
      emp118 = 1'bx;
      for (int i = 0; i < FRAME; i++) begin
         if (i == 117) emp117 = bus.empty;
         if (i == 118) emp118 = bus.empty;
         if (i < CPB)                bus.rx = 1'b0;
         else if (i < 9 * CPB)       bus.rx = d[(i - CPB) / CPB];
         else                        bus.rx = stop;
         bus.pop_front = (i == pop_at);
         @(negedge clk);
      end
      bus.pop_front = 1'b0;
   endtask

   task automatic pop_one();
      bus.pop_front = 1'b1;
      @(negedge clk);
      bus.pop_front = 1'b0;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.rx        = 1'b1;
      bus.pop_front = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " data_out"},    bus.data_out,    8'h00);
      check({tag, " empty"},       bus.empty,       1);
      check({tag, " full"},        bus.full,        0);
      check({tag, " level"},       bus.level,       0);
      check({tag, " frame_error"}, bus.frame_error, 0);
      check({tag, " error"},       bus.error,       0);
   endtask

   logic e117, e118;
   int   fe0;

   initial begin
      vecs[0] = '{8'hA5, 1'b1,  0, 8'hA5, 1, 0};
      vecs[1] = '{8'h3C, 1'b0, 40, 8'h00, 0, 1};
      vecs[2] = '{8'h11, 1'b1,  0, 8'h11, 1, 0};
      vecs[3] = '{8'h00, 1'b1,  0, 8'h00, 1, 0};
      vecs[4] = '{8'hFF, 1'b1,  0, 8'hFF, 1, 0};

      do_reset();
      check_reset_values("reset");

      foreach (vecs[i]) begin
         fe0 = fe_count;
         send_frame(vecs[i].data, vecs[i].stop, -1, e117, e118);
         if (!vecs[i].stop) begin
            bus.rx = 1'b0;
            repeat (vecs[i].hold_low) @(negedge clk);
            bus.rx = 1'b1;
         end
         repeat (4) @(negedge clk);
         check($sformatf("vec%0d empty before push", i), e117, 1);
         check($sformatf("vec%0d empty after push", i), e118, (vecs[i].exp_level != 0) ? 0 : 1);
         check($sformatf("vec%0d level", i), bus.level, vecs[i].exp_level);
         check($sformatf("vec%0d data_out", i), bus.data_out, vecs[i].exp_data);
         check($sformatf("vec%0d frame_error pulses", i), fe_count - fe0, vecs[i].exp_fe);
         if (vecs[i].exp_level != 0) begin
            pop_one();
            check($sformatf("vec%0d empty after pop", i), bus.empty, 1);
         end
      end

      // Short low glitch on an idle line must be rejected.
      fe0    = fe_count;
      bus.rx = 1'b0;
      repeat (3) @(negedge clk);
      bus.rx = 1'b1;
      repeat (20) @(negedge clk);
      check("glitch fsm idle", 32'(dut.u_rx.state_q), 32'(IDLE));
      check("glitch level", bus.level, 0);
      check("glitch frame_error", fe_count - fe0, 0);
      check("glitch error", bus.error, 0);

      // Overflow: six frames into four entries, oldest four retained.
      for (int k = 1; k <= 6; k++) begin
         send_frame(8'(k), 1'b1, -1, e117, e118);
         repeat (2) @(negedge clk);
      end
      check("ovf level", bus.level, 4);
      check("ovf full", bus.full, 1);
      check("ovf error", bus.error, 1);
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("ovf pop%0d data", k), bus.data_out, k);
         pop_one();
      end
      check("ovf drained empty", bus.empty, 1);
      check("ovf error sticky", bus.error, 1);

      // Full FIFO: pop lands in the same cycle as the fifth push.
      do_reset();
      check("rst clears error", bus.error, 0);
      for (int k = 1; k <= 4; k++) begin
         send_frame(8'(k), 1'b1, -1, e117, e118);
         repeat (2) @(negedge clk);
      end
      check("pp full before", bus.full, 1);
      send_frame(8'h05, 1'b1, 117, e117, e118);
      repeat (2) @(negedge clk);
      check("pp level", bus.level, 4);
      check("pp error", bus.error, 0);
      check("pp full", bus.full, 1);
      for (int k = 2; k <= 5; k++) begin
         check($sformatf("pp pop%0d data", k), bus.data_out, k);
         pop_one();
      end
      check("pp drained empty", bus.empty, 1);

      // Reset in the middle of a frame discards it.
      for (int i = 0; i < 50; i++) begin
         bus.rx = (i < CPB) ? 1'b0 : 1'b1;
         @(negedge clk);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_reset_values("midrst");
      repeat (4) @(negedge clk);
      send_frame(8'h5A, 1'b1, -1, e117, e118);
      repeat (4) @(negedge clk);
      check("midrst level", bus.level, 1);
      check("midrst data_out", bus.data_out, 8'h5A);
      pop_one();
      check("midrst empty", bus.empty, 1);
      check("midrst error before", bus.error, 0);
      pop_one();
      check("pop on empty error", bus.error, 1);
      check("pop on empty level", bus.level, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rx_pipe.md
RX_PIPE -- requirements
Module: rx_pipe

Interface
REQ-001 Parameter CLK_FREQ, default 12_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9_600, line bit rate.
REQ-003 Parameter DEPTH, default 16, FIFO entries; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 pop_front  input  1  consumer removes the head byte this cycle.
REQ-008 data_out  output  8  head byte (first-word-fall-through).
REQ-009 empty  output  1  FIFO holds no byte.
REQ-010 full  output  1  FIFO holds DEPTH bytes.
REQ-011 level  output  $clog2(DEPTH)+1  current byte count.
REQ-012 frame_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-013 error  output  1  sticky: overrun or pop on empty.

Function
REQ-014 rx passes through a 2-flop synchronizer before any use; both flops reset to 1.
REQ-015 CLKS_PER_BIT = CLK_FREQ/BAUD (integer division); HALF = CLKS_PER_BIT/2.
REQ-016 Receiver FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-017 IDLE: synchronized rx = 0 -> START, bit counter cleared.
REQ-018 START: after HALF clocks re-sample; rx = 1 -> IDLE (glitch rejected, nothing pushed); rx = 0 -> DATA.
REQ-019 DATA: sample every CLKS_PER_BIT clocks, shift in LSB first; after the 8th sample -> STOP.
REQ-020 STOP: sample after CLKS_PER_BIT clocks; rx = 1 -> push byte, go to IDLE; rx = 0 -> frame_error pulse, byte discarded, go to WAIT_IDLE.
REQ-021 WAIT_IDLE: stay until synchronized rx = 1, then go to IDLE (break condition yields exactly one frame_error).
REQ-022 The push strobe is registered: asserted the cycle after the stop-bit sample edge. empty falls one cycle after the push edge.
REQ-023 data_out equals storage at the read pointer while empty = 0; data_out is 8'h00 while empty = 1.
REQ-024 pop_front with empty = 0 advances the read pointer; the next byte appears on data_out on the following cycle.
REQ-025 Push with full = 0 writes and increments level.
REQ-026 Push with full = 1 and no pop: byte dropped, FIFO unchanged, error set.
REQ-027 Push and pop in the same cycle with full = 1: both performed, level unchanged, no error.
REQ-028 pop_front with empty = 1 is ignored and sets error; a same-cycle push is still accepted.
REQ-029 Pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH. full/empty derive from the pointer MSB and equality, and level = wr_ptr - rd_ptr.
REQ-030 error clears only on rst.

Reset
REQ-031 Asserting rst at any time forces the FSM to IDLE, discards any partial byte, and clears pointers and counters.
REQ-032 Reset output values: empty = 1, full = 0, level = 0, data_out = 8'h00, frame_error = 0, error = 0.
REQ-033 After rst deasserts, no start is detected until synchronized rx has been observed high and then falls.

Structure
REQ-034 Package uart_pkg holds: WIDTH = 8; the enum uart_rx_state_t; the function clks_per_bit(CLK_FREQ, BAUD).
REQ-035 Sub-module uart_rx contains the synchronizer, the FSM and the shift register, with outputs rx_data, rx_valid and rx_frame_error.
REQ-036 FIFO storage and pointer logic are inline in rx_pipe.

Verification (CLK_FREQ = 12_000_000, BAUD = 1_000_000, so 12 clocks per bit; DEPTH = 4)
REQ-037 Frame 8'hA5 with good stop bit -> empty = 0 with data_out = 8'hA5 within 2 cycles of the stop-bit sample, level = 1; pop -> empty = 1.
REQ-038 rx low pulse of 3 clocks from idle -> no push, no frame_error, FSM back in IDLE.
REQ-039 Frame 8'h3C with stop bit low, held low for 40 clocks -> exactly one frame_error pulse, level = 0, next good frame 8'h11 received.
REQ-040 Six frames 8'h01..8'h06 with no pops -> level = 4, full = 1, error = 1; pops yield 8'h01..8'h04 in order.
REQ-041 Full FIFO, pop in the same cycle as the 5th push -> level stays 4, error = 0, order preserved.
REQ-042 rst asserted mid-DATA of 8'hFF, then 8'h5A sent -> only 8'h5A appears; pop on empty -> error = 1.
